instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Front-end stage of the MIPS core. It owns the program counter, issues word fetches to instruction memory over a req/ack handshake, buffers returned instructions in a small prefetch queue, and hands them to decode (control unit and register file) over a valid/ready interface. Branch and jump resolution from the execute side redirects it through a single flush port.

## Interface
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch address after reset; word-aligned.

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request, registered
- imem_addr  out  32  fetch byte address, word-aligned, registered
- imem_ack  in  1  request accepted, with data valid this cycle
- imem_rdata  in  32  instruction word, sampled when imem_ack=1
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0
- inst_valid  out  1  queue head holds an instruction
- inst_ready  in  1  decode accepts the head this cycle
- inst  out  32  head instruction
- inst_pc  out  32  address of the head instruction
- stall_cycles  out  32  decode-starvation counter; present only with IFU_STALL_COUNT_EN

## Operation
- Bus rule:
  - Once imem_req=1, it stays high with imem_addr stable until the cycle imem_ack=1.
  - At most one request is outstanding.
  - imem_ack is ignored while imem_req=0.
- FSM states:
  - IDLE: no request outstanding.
    - Go to REQ, with imem_addr = fetch_pc, when count < DEPTH and redirect=0.
  - REQ: waiting for ack.
    - On ack without redirect: push {fetch_pc, imem_rdata} and advance fetch_pc += 4.
    - After the push, stay in REQ with the new address if (count + 1 − pop) < DEPTH. Otherwise go to IDLE.
    - On redirect without ack: go to DROP.
    - On redirect with ack: discard the data and go to IDLE.
  - DROP: the old request is still held on the bus.
    - On ack: discard the data and go to IDLE.
    - A further redirect only updates fetch_pc.
- Redirect, in any state:
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - The queue is flushed the same edge (count=0, pointers reset); a same-cycle pop and push are both void.
  - inst_valid=0 the next cycle.
- Queue:
  - Circular FIFO; read and write pointers wrap modulo DEPTH.
  - pop = inst_valid & inst_ready; push and pop in the same cycle leaves count unchanged.
  - inst_valid = (count != 0).
  - inst and inst_pc are driven combinationally from the head entry.
- fetch_pc arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset values:
  - State IDLE, fetch_pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC.
  - Queue empty; inst_valid = 0; all entries zero, so inst = 0 and inst_pc = 0.
  - stall_cycles = 0.
- Reset asserted mid-request abandons it immediately: imem_req drops asynchronously and no data is pushed.

## Timing
- IDLE→REQ takes one edge, so imem_req rises the cycle after the condition holds.
- Ack in cycle N makes the entry visible as inst_valid=1 in cycle N+1.
- The first fetch after reset release goes out on the first edge with reset high.
- Peak throughput is one instruction per cycle with imem_ack held at 1 and inst_ready=1.
- Redirect at edge N means imem_addr = redirect_pc no earlier than edge N+1 (from IDLE or REQ+ack), or the edge after the dropped ack (from DROP).

## Configuration
- IFU_STALL_COUNT_EN defined:
  - The stall_cycles port and its 32-bit register exist.
  - It increments each cycle with inst_ready=1 and inst_valid=0, saturates at 32'hFFFF_FFFF, and clears only on reset.
- Undefined: the port and register are absent; all other behaviour is identical.

## Test plan
- Reset release, imem_ack tied to 1, inst_ready=1 → imem_addr runs 0,4,8,…, one per cycle; inst_pc follows one cycle behind; inst equals memory contents.
- inst_ready=0 with ack=1 → exactly DEPTH (4) entries are fetched, then imem_req=0 and inst_valid stays 1; raising ready drains in order, and fetch resumes at 32'h10.
- Ack delayed 3 cycles → imem_req and imem_addr are held stable all 3 cycles; one push on the ack cycle.
- redirect_pc=32'h0000_0103 during REQ without ack → state DROP, the late ack's data is discarded, the next imem_addr is 32'h100, and the queue is empty the cycle after the redirect.
- redirect coincident with ack and pop → queue empty, no push, next fetch at redirect_pc; also fetch_pc 32'hFFFF_FFFC fetches 0 next.
- With IFU_STALL_COUNT_EN, ready=1 and 10 starved cycles → stall_cycles=10; reset asserted mid-REQ → imem_req=0 immediately and stall_cycles=0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory req/ack channel, redirect port from
// execute, and the valid/ready instruction hand-off to decode.
//   master : fetch unit view (drives imem_req/imem_addr and the inst_* outputs)
//   slave  : environment view (memory, execute and decode side)
interface instruction_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding word fetch
// at a time, buffers returned words in a DEPTH-entry circular queue and hands
// the head to decode. A redirect flushes the queue and restarts fetch.
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   bus          instruction_fetch_unit_if.master (imem, redirect, decode hand-off)
//   stall_cycles decode-starvation counter, only when IFU_STALL_COUNT_EN is defined
// Optional feature macro: IFU_STALL_COUNT_EN
module instruction_fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
`ifdef IFU_STALL_COUNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  state_e          state_q;
  logic [31:0]     fetch_pc_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_after;
  logic [31:0]     q_inst [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic            pop, push;
  logic [31:0]     redirect_word;

  assign redirect_word  = {bus.redirect_pc[31:2], 2'b00};
  assign bus.inst_valid = (count_q != '0);
  assign bus.inst       = q_inst[rd_ptr_q];
  assign bus.inst_pc    = q_pc[rd_ptr_q];
  assign pop            = bus.inst_valid & bus.inst_ready;
  // Data accepted in REQ is pushed unless a redirect voids it the same edge.
  assign push           = (state_q == StReq) & bus.imem_ack & ~bus.redirect;
  // Occupancy after this edge's push; decides whether to keep fetching.
  assign count_after    = count_q + CntW'(1) - CntW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      bus.imem_req  <= 1'b0;
      bus.imem_addr <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i]   <= '0;
      end
    end else begin
      // Queue bookkeeping
      if (bus.redirect) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) begin
          q_inst[wr_ptr_q] <= bus.imem_rdata;
          q_pc[wr_ptr_q]   <= fetch_pc_q;
          wr_ptr_q         <= wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PtrW'(1);
        end
        count_q <= count_q + CntW'(push) - CntW'(pop);
      end

      // Fetch control
      unique case (state_q)
        StIdle: begin
          if (bus.redirect) begin
            fetch_pc_q <= redirect_word;
          end else if (count_q < CntW'(DEPTH)) begin
            state_q       <= StReq;
            bus.imem_req  <= 1'b1;
            bus.imem_addr <= fetch_pc_q;
          end
        end
        StReq: begin
          if (bus.redirect) begin
            fetch_pc_q <= redirect_word;
            if (bus.imem_ack) begin
              state_q      <= StIdle;
              bus.imem_req <= 1'b0;
            end else begin
              // Request must stay on the bus until acked; its data is dropped.
              state_q <= StDrop;
            end
          end else if (bus.imem_ack) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
            if (count_after < CntW'(DEPTH)) begin
              bus.imem_addr <= fetch_pc_q + 32'd4;
            end else begin
              state_q      <= StIdle;
              bus.imem_req <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (bus.redirect) begin
            fetch_pc_q <= redirect_word;
          end
          if (bus.imem_ack) begin
            state_q      <= StIdle;
            bus.imem_req <= 1'b0;
          end
        end
        default: begin
          state_q      <= StIdle;
          bus.imem_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_STALL_COUNT_EN
  // Counts cycles decode was ready but starved; saturates, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (bus.inst_ready && !bus.inst_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule
